prog_loader_ctrl: RTL and testbench

Synthesizable boot-time program loader controller. It consumes a byte stream of address/data/done records from a host interface (UART or SPI receiver), packs the bytes into 32-bit little-endian words with byte enables, and writes them into instruction memory through a request/grant port. After the done record it asserts `boot_done_o`, which releases the core from reset.

---
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/prog_loader_packer.sv | 66 ++++++
 rtl/prog_loader_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_prog_loader_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional build macro: PROG_LOADER_CHECKSUM_EN (per-record checksum byte).
package prog_loader_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int BE_W   = WORD_W / 8;

  localparam logic [7:0] OP_ADDR = 8'hA5;
  localparam logic [7:0] OP_DATA = 8'h5A;
  localparam logic [7:0] OP_DONE = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_CSUM,
    S_FLUSH,
    S_DONE,
    S_ERR
  } loader_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_word_t;

endpackage

// File: rtl/prog_loader_packer.sv
// Byte-lane word buffer with enable accumulation and a
// req/gnt write port; issues on lane 3 or on flush.
module prog_loader_packer
  import prog_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [7:0]        byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  input  logic              mem_gnt_i,
  output logic              mem_req_o,
  output mem_word_t         word_o
);

  logic [WORD_W-1:0] lane_q, lane_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-3:0] wa_q, wa_d;
  logic [1:0]        lane;
  logic              issue;

  assign lane = addr_i[1:0];

  always_comb begin
    lane_d = lane_q;
    be_d   = be_q;
    wa_d   = wa_q;
    if (wr_i) begin
      lane_d[{lane, 3'b000} +: 8] = byte_i;
      be_d[lane] = 1'b1;
      wa_d       = addr_i[ADDR_W-1:2];
    end
  end

  assign issue = (wr_i && (lane == 2'd3))
              || (flush_i && (be_q != '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q    <= '0;
      be_q      <= '0;
      wa_q      <= '0;
      mem_req_o <= 1'b0;
      word_o    <= '0;
    end else begin
      if (mem_req_o && mem_gnt_i)
        mem_req_o <= 1'b0;
      // The controller stalls input while req is up, so
      // issue never overlaps an outstanding request.
      if (issue) begin
        mem_req_o    <= 1'b1;
        word_o.addr  <= {wa_d, 2'b00};
        word_o.wdata <= lane_d;
        word_o.be    <= be_d;
        lane_q       <= '0;
        be_q         <= '0;
      end else begin
        lane_q <= lane_d;
        be_q   <= be_d;
        wa_q   <= wa_d;
      end
    end
  end

endmodule

// File: rtl/prog_loader_ctrl.sv
// Boot loader: parses address/data/done records into imem writes.
// PROG_LOADER_CHECKSUM_EN adds a zero-sum checksum byte per data record.
module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BOOT_ADDR = 32'h0000_0000,
  parameter int                TIMEOUT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic [BE_W-1:0]   mem_be_o,
  input  logic              mem_gnt_i,
  output logic              boot_done_o,
  output logic              err_o
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        cnt_q;
  logic              rdy;
  logic              accept;
  logic              pk_wr;
  logic              pk_flush;
  logic              tmo;
  mem_word_t         word;

  assign accept = in_valid_i && in_ready_o;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_fin;

  assign sum_fin = sum_q + in_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      sum_q <= '0;
    else if (accept && state_q == S_CNT)
      sum_q <= in_data_i;
    else if (accept && state_q == S_DATA)
      sum_q <= sum_fin;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (in_data_i == OP_ADDR): state_d = S_ADDR;
            (in_data_i == OP_DATA): state_d = S_CNT;
            (in_data_i == OP_DONE): state_d = S_DONE;
            default:                state_d = S_ERR;
          endcase
        end
      end
      S_ADDR:
        if (accept && cnt_q == 9'd1)
          state_d = S_IDLE;
      S_CNT:
        if (accept)
          state_d = S_DATA;
      S_DATA:
        if (accept && cnt_q == 9'd1)
          state_d = S_FLUSH;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM:
        if (accept)
          state_d = (sum_fin == 8'h00) ? S_IDLE : S_ERR;
      S_FLUSH:
        if (!mem_req_o)
          state_d = S_CSUM;
`else
      S_FLUSH:
        if (!mem_req_o)
          state_d = S_IDLE;
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    if (tmo)
      state_d = S_ERR;
  end

  always_comb begin
    rdy         = 1'b0;
    pk_flush    = 1'b0;
    boot_done_o = 1'b0;
    err_o       = 1'b0;
    unique case (state_q)
      S_IDLE, S_ADDR, S_CNT, S_DATA, S_CSUM:
        rdy = !mem_req_o;
      S_FLUSH:
        pk_flush = !mem_req_o;
      S_DONE:
        boot_done_o = 1'b1;
      S_ERR: begin
        rdy   = 1'b1;
        err_o = 1'b1;
      end
      default: ;
    endcase
    in_ready_o = rdy && rst_ni;
    pk_wr      = accept && (state_q == S_DATA);
  end

  // cnt_q: remaining address bytes in ADDR, data bytes in DATA
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= BOOT_ADDR;
      cnt_q  <= '0;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE:
          cnt_q <= 9'd4;
        S_ADDR: begin
          addr_q <= {in_data_i, addr_q[ADDR_W-1:8]};
          cnt_q  <= cnt_q - 9'd1;
        end
        S_CNT:
          cnt_q <= (in_data_i == 8'h00) ? 9'd256
                                        : {1'b0, in_data_i};
        S_DATA: begin
          addr_q <= addr_q + 32'd1;
          cnt_q  <= cnt_q - 9'd1;
        end
        default: ;
      endcase
    end
  end

  generate
    if (TIMEOUT_W > 0) begin : g_tmo
      localparam logic [TIMEOUT_W-1:0] TMO_LAST =
        {TIMEOUT_W{1'b1}} - 1'b1;
      logic [TIMEOUT_W-1:0] idle_q;
      logic                 timed;

      assign timed = (state_q == S_ADDR) || (state_q == S_CNT)
                  || (state_q == S_DATA) || (state_q == S_CSUM);

      // A memory stall is not host idleness, so it restarts the count.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
          idle_q <= '0;
        else if (!timed || accept || mem_req_o)
          idle_q <= '0;
        else
          idle_q <= idle_q + 1'b1;
      end

      assign tmo = timed && !accept && !mem_req_o
                && (idle_q == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo = 1'b0;
    end
  endgenerate

  prog_loader_packer u_packer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_i      (pk_wr),
    .byte_i    (in_data_i),
    .addr_i    (addr_q),
    .flush_i   (pk_flush),
    .mem_gnt_i (mem_gnt_i),
    .mem_req_o (mem_req_o),
    .word_o    (word)
  );

  assign mem_addr_o  = word.addr;
  assign mem_wdata_o = word.wdata;
  assign mem_be_o    = word.be;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl: table vectors,
// directed corner sequences and a randomized stream model.
module tb_prog_loader_ctrl;
  import prog_loader_pkg::*;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        boot_done;
  logic        err;

  always #5 clk = ~clk;

  prog_loader_ctrl #(
    .BOOT_ADDR (32'h0000_0000),
    .TIMEOUT_W (6)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_gnt_i   (mem_gnt),
    .boot_done_o (boot_done),
    .err_o       (err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    int  start;
    int  len;
    int  cs_pos;
    int  nw;
    wr_t w0;
    wr_t w1;
    bit  done;
    bit  err;
  } vec_t;

  wr_t        got[$];
  wr_t        exp_q[$];
  logic [7:0] tv_bytes[$];
  vec_t       tv[$];
  logic [7:0] rs[$];
  int         vecs = 0;
  int         miss = 0;
  bit         stop;

  always @(posedge clk)
    if (rst_n && mem_req && mem_gnt)
      got.push_back({mem_addr, mem_wdata, mem_be});

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic chkw(input string nm, input wr_t act, input wr_t want);
    vecs++;
    if (act !== want) begin
      miss++;
      $display("FAIL %s: got a=%h d=%h be=%h want a=%h d=%h be=%h",
               nm, act.addr, act.data, act.be,
               want.addr, want.data, want.be);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    got.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vecs++;
      miss++;
      $display("FAIL send_timeout: byte %h never accepted", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic add_vec(input logic [7:0] b[$], input int cs_pos,
                         input int nw, input wr_t w0, input wr_t w1,
                         input bit d, input bit e);
    vec_t v;
    v.start  = tv_bytes.size();
    v.len    = b.size();
    v.cs_pos = cs_pos;
    v.nw     = nw;
    v.w0     = w0;
    v.w1     = w1;
    v.done   = d;
    v.err    = e;
    foreach (b[i]) tv_bytes.push_back(b[i]);
    tv.push_back(v);
  endtask

  // Protocol-level reference: walk records, group data bytes by word.
  task automatic model(input logic [7:0] s[$], output bit md,
                       output bit me);
    logic [31:0] a;
    logic [7:0]  op;
    logic [7:0]  sum;
    wr_t         w;
    bit          open;
    int          i;
    int          n;
    a  = 32'h0;
    i  = 0;
    w  = '0;
    md = 1'b0;
    me = 1'b0;
    exp_q.delete();
    while (i < s.size() && !md && !me) begin
      op = s[i];
      i++;
      if (op == 8'hA5) begin
        a = {s[i+3], s[i+2], s[i+1], s[i]};
        i += 4;
      end else if (op == 8'h5A) begin
        n   = (s[i] == 8'h00) ? 256 : int'(s[i]);
        sum = s[i];
        i++;
        open = 1'b0;
        for (int k = 0; k < n; k++) begin
          if (open && w.addr != {a[31:2], 2'b00}) begin
            exp_q.push_back(w);
            open = 1'b0;
          end
          if (!open) begin
            w    = '0;
            w.addr = {a[31:2], 2'b00};
            open = 1'b1;
          end
          w.data[{a[1:0], 3'b000} +: 8] = s[i];
          w.be[a[1:0]] = 1'b1;
          sum = sum + s[i];
          i++;
          a = a + 32'd1;
        end
        if (open) exp_q.push_back(w);
        if (CSUM) begin
          sum = sum + s[i];
          i++;
          if (sum != 8'h00) me = 1'b1;
        end
      end else if (op == 8'hF0) begin
        md = 1'b1;
      end else begin
        me = 1'b1;
      end
    end
  endtask

  task automatic gen();
    int          nrec;
    int          cnt;
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] a;
    rs.delete();
    nrec = $urandom_range(1, 5);
    for (int r = 0; r < nrec; r++) begin
      case ($urandom % 10)
        0, 1, 2: begin
          a = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16)
                                  : $urandom;
          rs.push_back(8'hA5);
          for (int k = 0; k < 4; k++) rs.push_back(a[8*k +: 8]);
        end
        9: begin
          do b = 8'($urandom);
          while (b == 8'hA5 || b == 8'h5A || b == 8'hF0);
          rs.push_back(b);
        end
        default: begin
          cnt = ($urandom % 25 == 0) ? 0 : $urandom_range(1, 9);
          rs.push_back(8'h5A);
          rs.push_back(8'(cnt));
          sum = 8'(cnt);
          for (int k = 0; k < ((cnt == 0) ? 256 : cnt); k++) begin
            b = 8'($urandom);
            rs.push_back(b);
            sum = sum + b;
          end
          if (CSUM)
            rs.push_back(8'h00 - sum + (($urandom % 8 == 0) ? 8'h01 : 8'h00));
        end
      endcase
    end
    rs.push_back(8'hF0);
  endtask

  initial begin
    bit md;
    bit me;
    wr_t snap;
    int  n;

    add_vec('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h5A, 8'h04,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h52, 8'hF0}, 11, 1,
            {32'h1000, 32'h4433_2211, 4'hF}, '0, 1'b1, 1'b0);
    add_vec('{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h5A, 8'h03,
              8'hAA, 8'hBB, 8'hCC, 8'hCC, 8'hF0}, 10, 2,
            {32'h1000, 32'hBBAA_0000, 4'hC},
            {32'h1004, 32'h0000_00CC, 4'h1}, 1'b1, 1'b0);
    add_vec('{8'h33, 8'h5A, 8'h01, 8'h55, 8'hF0}, -1, 0,
            '0, '0, 1'b0, 1'b1);
    add_vec('{8'hA5, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'h04,
              8'h01, 8'h02, 8'h03, 8'h04, 8'hF2, 8'hF0}, 11, 2,
            {32'hFFFF_FFFC, 32'h0201_0000, 4'hC},
            {32'h0000_0000, 32'h0000_0403, 4'h3}, 1'b1, 1'b0);
    add_vec('{8'h5A, 8'h02, 8'h77, 8'h88, 8'hFF, 8'hF0}, 4, 1,
            {32'h0, 32'h0000_8877, 4'h3}, '0, 1'b1, 1'b0);
    add_vec('{8'hF0}, -1, 0, '0, '0, 1'b1, 1'b0);

    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_done", boot_done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", in_ready, 1);

    foreach (tv[v]) begin
      do_reset();
      mem_gnt = 1'b1;
      for (int k = 0; k < tv[v].len; k++) begin
        if (k == tv[v].cs_pos && !CSUM) continue;
        send(tv_bytes[tv[v].start + k]);
        if (k == 0 && tv_bytes[tv[v].start] == 8'h33)
          chk($sformatf("v%0d_err_next", v), err, 1);
      end
      if (tv[v].done)
        chk($sformatf("v%0d_done_next", v), boot_done, 1);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_nwr", v), got.size(), tv[v].nw);
      if (tv[v].nw > 0 && got.size() > 0)
        chkw($sformatf("v%0d_w0", v), got[0], tv[v].w0);
      if (tv[v].nw > 1 && got.size() > 1)
        chkw($sformatf("v%0d_w1", v), got[1], tv[v].w1);
      chk($sformatf("v%0d_done", v), boot_done, tv[v].done);
      chk($sformatf("v%0d_err", v), err, tv[v].err);
      chk($sformatf("v%0d_ready", v), in_ready, tv[v].err);
    end

    // Grant withheld: outputs held and input stalled while req is up.
    do_reset();
    mem_gnt = 1'b0;
    fork
      begin
        send(8'hA5); send(8'h00); send(8'h20); send(8'h00); send(8'h00);
        send(8'h5A); send(8'h08);
        for (int k = 1; k <= 8; k++) send(8'(k));
        if (CSUM) send(8'hD4);
      end
      begin
        for (int w = 0; w < 2; w++) begin
          n = 0;
          while (!mem_req && n < 400) begin
            @(negedge clk);
            n++;
          end
          chk("stall_req", mem_req, 1);
          snap = {mem_addr, mem_wdata, mem_be};
          for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chkw("stall_hold", {mem_addr, mem_wdata, mem_be}, snap);
            chk("stall_ready", in_ready, 0);
          end
          mem_gnt = 1'b1;
          @(negedge clk);
          mem_gnt = 1'b0;
        end
      end
    join
    mem_gnt = 1'b1;
    send(8'hF0);
    repeat (3) @(negedge clk);
    chk("stall_nwr", got.size(), 2);
    if (got.size() == 2) begin
      chkw("stall_w0", got[0], {32'h2000, 32'h0403_0201, 4'hF});
      chkw("stall_w1", got[1], {32'h2004, 32'h0807_0605, 4'hF});
    end
    chk("stall_done", boot_done, 1);

    // Reset with a request pending discards it.
    do_reset();
    mem_gnt = 1'b0;
    send(8'hA5); send(8'h00); send(8'h30); send(8'h00); send(8'h00);
    send(8'h5A); send(8'h04);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("pend_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_be", mem_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    send(8'hF0);
    repeat (3) @(negedge clk);
    chk("rst_mid_nwr", got.size(), 0);
    chk("rst_mid_done", boot_done, 1);

    // Inter-byte idle timeout inside an address record.
    do_reset();
    send(8'hA5);
    send(8'h00);
    repeat (40) @(negedge clk);
    chk("tmo_early", err, 0);
    repeat (60) @(negedge clk);
    chk("tmo_fire", err, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    mem_gnt = 1'b1;
    send(8'h5A); send(8'h01); send(8'h10); send(8'hEF); send(8'hF0);
    repeat (3) @(negedge clk);
    chk("cs_ok_nwr", got.size(), 1);
    chk("cs_ok_done", boot_done, 1);
    do_reset();
    send(8'h5A); send(8'h01); send(8'h10); send(8'hEE);
    chk("cs_bad_err", err, 1);
    send(8'hF0);
    repeat (3) @(negedge clk);
    chk("cs_bad_nwr", got.size(), 1);
    if (got.size() == 1)
      chkw("cs_bad_w", got[0], {32'h0, 32'h0000_0010, 4'h1});
    chk("cs_bad_done", boot_done, 0);
`endif

    for (int it = 0; it < 40; it++) begin
      do_reset();
      gen();
      model(rs, md, me);
      stop = 1'b0;
      fork
        begin
          foreach (rs[i]) send(rs[i]);
          stop = 1'b1;
        end
        begin
          while (!stop) begin
            @(negedge clk);
            mem_gnt = 1'($urandom % 2);
          end
        end
      join
      mem_gnt = 1'b1;
      repeat (10) @(negedge clk);
      chk($sformatf("rnd%0d_nwr", it), got.size(), exp_q.size());
      foreach (exp_q[i])
        if (i < got.size())
          chkw($sformatf("rnd%0d_w%0d", it, i), got[i], exp_q[i]);
      chk($sformatf("rnd%0d_done", it), boot_done, md);
      chk($sformatf("rnd%0d_err", it), err, me);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
